// File: rtl/jump_trajectory_pkg.sv
// Shared types and constants for the jump trajectory engine.
package jump_trajectory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    JUDGE  = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam int unsigned SCREEN_MAX      = 1023;
  localparam int unsigned DEF_STEP_PX     = 4;
  localparam int unsigned DEF_FRAMES_LOG2 = 4;
  localparam int unsigned DEF_PEAK        = 32;

endpackage

// File: rtl/jump_trajectory.sv
// Bottle flight: launches on button release, steps a parabolic arc once per
// frame, then judges the landing against the target window and keeps score.
module jump_trajectory
  import jump_trajectory_pkg::*;
#(
  parameter int unsigned STEP_PX     = DEF_STEP_PX,
  parameter int unsigned FRAMES_LOG2 = DEF_FRAMES_LOG2,
  parameter int unsigned PEAK        = DEF_PEAK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] jump_dist,
  input  logic       end_of_jump,
  input  logic       frame_tick,
  input  logic [9:0] start_x,
  input  logic [9:0] target_lo,
  input  logic [9:0] target_hi,
  output logic [9:0] pos_x,
  output logic [7:0] pos_y_off,
  output logic       busy,
  output logic       land_valid,
  output logic       land_ok,
  output logic [7:0] score,
  output logic       game_over
);

  localparam int unsigned FW     = FRAMES_LOG2 + 1;
  localparam int unsigned N      = 1 << FRAMES_LOG2;
  localparam int unsigned CH_W   = 8 + 16;
  localparam int unsigned PROD_W = 10 + FW;
  localparam int unsigned SUM_W  = 11;
  localparam int unsigned Y_W    = 8 + 2 * FW;
  localparam int unsigned Y_SH   = 2 * FRAMES_LOG2 - 2;

  state_t            state;
  logic [FW-1:0]     f;
  logic [9:0]        total;
  logic [9:0]        x0;

  logic [CH_W-1:0]   launch_prod;
  logic [9:0]        launch_total;
  logic [FW-1:0]     f_next;
  logic [PROD_W-1:0] x_prod;
  logic [SUM_W-1:0]  x_sum;
  logic [9:0]        x_next;
  logic [Y_W-1:0]    y_prod;
  logic [7:0]        y_next;
  logic              hit_next;

  // Position for the next frame, evaluated from f+1 so the register update
  // and the counter advance land on the same edge.
  always_comb begin
    launch_prod  = CH_W'(jump_dist) * CH_W'(STEP_PX);
    launch_total = (launch_prod > CH_W'(SCREEN_MAX)) ? 10'(SCREEN_MAX) : 10'(launch_prod);
    f_next       = f + FW'(1);
    x_prod       = PROD_W'(total) * PROD_W'(f_next);
    x_sum        = SUM_W'(x0) + SUM_W'(x_prod >> FRAMES_LOG2);
    x_next       = (x_sum > SUM_W'(SCREEN_MAX)) ? 10'(SCREEN_MAX) : 10'(x_sum);
    y_prod       = Y_W'(PEAK) * Y_W'(f_next) * Y_W'(FW'(N) - f_next);
    y_next       = 8'(y_prod >> Y_SH);
    hit_next     = (target_lo <= x_next) && (x_next <= target_hi);
  end

  // Judgement is computed on the final frame edge so land_valid and land_ok
  // are both presented during the single JUDGE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      f          <= '0;
      total      <= '0;
      x0         <= '0;
      pos_x      <= '0;
      pos_y_off  <= '0;
      busy       <= 1'b0;
      land_valid <= 1'b0;
      land_ok    <= 1'b0;
      score      <= '0;
      game_over  <= 1'b0;
    end else begin
      land_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (end_of_jump && (jump_dist != 8'd0)) begin
            total     <= launch_total;
            x0        <= start_x;
            pos_x     <= start_x;
            pos_y_off <= '0;
            f         <= '0;
            busy      <= 1'b1;
            state     <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (frame_tick) begin
            f         <= f_next;
            pos_x     <= x_next;
            pos_y_off <= y_next;
            if (f_next == FW'(N)) begin
              land_valid <= 1'b1;
              land_ok    <= hit_next;
              state      <= JUDGE;
              if (hit_next) begin
                if (score != 8'd255) score <= score + 8'd1;
              end else begin
                game_over <= 1'b1;
              end
            end
          end
        end
        JUDGE: begin
          busy  <= 1'b0;
          state <= land_ok ? IDLE : DEAD;
        end
        DEAD: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_trajectory.sv
// Randomized self-checking bench for jump_trajectory against an arithmetic model.
module tb_jump_trajectory;

  localparam int STEP = 4;
  localparam int L    = 4;
  localparam int N    = 16;
  localparam int PK   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] jump_dist = '0;
  logic       end_of_jump = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] start_x = '0;
  logic [9:0] target_lo = '0;
  logic [9:0] target_hi = '0;
  logic [9:0] pos_x;
  logic [7:0] pos_y_off;
  logic       busy;
  logic       land_valid;
  logic       land_ok;
  logic [7:0] score;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;
  int lv_count = 0;
  int exp_score = 0;
  int exp_over = 0;

  jump_trajectory #(.STEP_PX(STEP), .FRAMES_LOG2(L), .PEAK(PK)) dut (
    .clk(clk), .rst(rst), .jump_dist(jump_dist), .end_of_jump(end_of_jump),
    .frame_tick(frame_tick), .start_x(start_x), .target_lo(target_lo),
    .target_hi(target_hi), .pos_x(pos_x), .pos_y_off(pos_y_off), .busy(busy),
    .land_valid(land_valid), .land_ok(land_ok), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (land_valid === 1'b1) lv_count++;

  // Horizontal position after f frames: linear share of the clamped distance.
  function automatic int model_x(input int sx, input int d, input int fr);
    int tot;
    int x;
    tot = d * STEP;
    if (tot > 1023) tot = 1023;
    x = sx + (tot * fr) / N;
    return (x > 1023) ? 1023 : x;
  endfunction

  // Parabolic height scaled so the apex at N/2 equals PK.
  function automatic int model_y(input int fr);
    return (PK * fr * (N - fr)) / (N * N / 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_score = 0;
    exp_over = 0;
  endtask

  task automatic run_flight(input int sx, input int d, input int lo, input int hi,
                            input bit interfere, input int abort_at);
    int lv0;
    int ex;
    int ey;
    bit ok;
    lv0 = lv_count;
    start_x = 10'(sx); jump_dist = 8'(d); target_lo = 10'(lo); target_hi = 10'(hi);
    end_of_jump = 1'b1;
    frame_tick = 1'b1;
    step();
    end_of_jump = 1'b0; frame_tick = 1'b0;
    start_x = 10'($urandom);
    n_cmp++;
    if (busy !== 1'b1 || pos_x !== 10'(sx) || pos_y_off !== 8'd0) begin
      n_bad++;
      $display("FAIL launch: busy=%0b pos_x=%0d pos_y=%0d want 1/%0d/0", busy, pos_x, pos_y_off, sx);
    end
    for (int k = 1; k <= N; k++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        step();
        n_cmp++;
        if (pos_x !== 10'(model_x(sx, d, k - 1)) || pos_y_off !== 8'(model_y(k - 1))) begin
          n_bad++;
          $display("FAIL hold f=%0d: pos_x=%0d pos_y=%0d want %0d/%0d", k - 1, pos_x, pos_y_off,
                   model_x(sx, d, k - 1), model_y(k - 1));
        end
      end
      frame_tick = 1'b1;
      if (interfere && (k == 3 || k == 9)) begin
        end_of_jump = 1'b1;
        jump_dist = 8'($urandom_range(1, 255));
      end
      step();
      frame_tick = 1'b0; end_of_jump = 1'b0;
      ex = model_x(sx, d, k);
      ey = model_y(k);
      n_cmp++;
      if (pos_x !== 10'(ex) || pos_y_off !== 8'(ey)) begin
        n_bad++;
        $display("FAIL tick %0d: pos_x=%0d pos_y=%0d want %0d/%0d", k, pos_x, pos_y_off, ex, ey);
      end
      if (k == abort_at) begin
        rst = 1'b1; end_of_jump = 1'b1; jump_dist = 8'd10; frame_tick = 1'b1;
        step();
        rst = 1'b0; end_of_jump = 1'b0; frame_tick = 1'b0;
        exp_score = 0; exp_over = 0;
        n_cmp++;
        if (pos_x !== 10'd0 || pos_y_off !== 8'd0 || busy !== 1'b0 || land_valid !== 1'b0 ||
            land_ok !== 1'b0 || score !== 8'd0 || game_over !== 1'b0) begin
          n_bad++;
          $display("FAIL abort: x=%0d y=%0d busy=%0b lv=%0b ok=%0b score=%0d over=%0b want all 0",
                   pos_x, pos_y_off, busy, land_valid, land_ok, score, game_over);
        end
        step();
        n_cmp++;
        if (lv_count !== lv0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL abort_pulse: land pulses=%0d busy=%0b want %0d/0", lv_count - lv0, busy, 0);
        end
        return;
      end
    end
    ok = (lo <= ex) && (ex <= hi);
    n_cmp++;
    if (land_valid !== 1'b1 || land_ok !== ok || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL judge: lv=%0b ok=%0b busy=%0b want 1/%0b/1", land_valid, land_ok, busy, ok);
    end
    if (ok && exp_score < 255) exp_score++;
    if (!ok) exp_over = 1;
    step();
    n_cmp++;
    if (land_valid !== 1'b0 || busy !== 1'b0 || land_ok !== ok || score !== 8'(exp_score) ||
        game_over !== exp_over[0] || lv_count !== lv0 + 1) begin
      n_bad++;
      $display("FAIL after_judge: lv=%0b busy=%0b ok=%0b score=%0d over=%0b pulses=%0d want 0/0/%0b/%0d/%0d/1",
               land_valid, busy, land_ok, score, game_over, lv_count - lv0, ok, exp_score, exp_over);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; end_of_jump = 1'b1; jump_dist = 8'd10;
    step();
    rst = 1'b0; end_of_jump = 1'b0;
    n_cmp++;
    if (pos_x !== 10'd0 || pos_y_off !== 8'd0 || busy !== 1'b0 || land_valid !== 1'b0 ||
        land_ok !== 1'b0 || score !== 8'd0 || game_over !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: x=%0d y=%0d busy=%0b lv=%0b ok=%0b score=%0d over=%0b want all 0",
               pos_x, pos_y_off, busy, land_valid, land_ok, score, game_over);
    end
  endtask

  task automatic test_nominal();
    run_flight(100, 10, 130, 150, 1'b0, 0);
    n_cmp++;
    if (pos_x !== 10'd140 || pos_y_off !== 8'd0 || score !== 8'd1) begin
      n_bad++;
      $display("FAIL nominal_end: x=%0d y=%0d score=%0d want 140/0/1", pos_x, pos_y_off, score);
    end
  endtask

  task automatic test_zero_charge();
    start_x = 10'd500; jump_dist = 8'd0; end_of_jump = 1'b1;
    step();
    end_of_jump = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || pos_x !== 10'd140) begin
      n_bad++;
      $display("FAIL zero_charge: busy=%0b pos_x=%0d want 0/140", busy, pos_x);
    end
  endtask

  task automatic test_saturation();
    run_flight(1000, 255, 1020, 1023, 1'b0, 0);
    n_cmp++;
    if (pos_x !== 10'd1023 || land_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL saturation: pos_x=%0d ok=%0b want 1023/1", pos_x, land_ok);
    end
  endtask

  task automatic test_interference();
    run_flight(100, 10, 130, 150, 1'b1, 0);
    n_cmp++;
    if (pos_x !== 10'd140 || land_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL interference: pos_x=%0d ok=%0b want 140/1", pos_x, land_ok);
    end
  endtask

  task automatic test_reset_mid_flight();
    run_flight(100, 10, 130, 150, 1'b0, 5);
    test_nominal();
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int sx;
      int d;
      int ex;
      int lo;
      int hi;
      sx = $urandom_range(0, 1023);
      d = $urandom_range(1, 255);
      ex = model_x(sx, d, N);
      if ($urandom_range(0, 3) != 0) begin
        lo = ex - $urandom_range(0, 20); if (lo < 0) lo = 0;
        hi = ex + $urandom_range(0, 20); if (hi > 1023) hi = 1023;
      end else begin
        lo = (ex + 512) % 1024; hi = lo;
      end
      run_flight(sx, d, lo, hi, $urandom_range(0, 1) != 0, 0);
      if (exp_over != 0) do_reset();
    end
  endtask

  task automatic test_inverted_window();
    do_reset();
    run_flight(100, 10, 150, 130, 1'b0, 0);
    do_reset();
  endtask

  task automatic test_miss();
    int lv0;
    run_flight(100, 3, 130, 150, 1'b0, 0);
    n_cmp++;
    if (pos_x !== 10'd112 || land_ok !== 1'b0 || game_over !== 1'b1) begin
      n_bad++;
      $display("FAIL miss: pos_x=%0d ok=%0b over=%0b want 112/0/1", pos_x, land_ok, game_over);
    end
    lv0 = lv_count;
    for (int i = 0; i < 4; i++) begin
      start_x = 10'd7; jump_dist = 8'd10; end_of_jump = 1'b1; frame_tick = 1'b1;
      step();
      end_of_jump = 1'b0; frame_tick = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || pos_x !== 10'd112 || game_over !== 1'b1 || lv_count !== lv0) begin
        n_bad++;
        $display("FAIL dead_hold: busy=%0b pos_x=%0d over=%0b pulses=%0d want 0/112/1/0",
                 busy, pos_x, game_over, lv_count - lv0);
      end
    end
    do_reset();
    n_cmp++;
    if (game_over !== 1'b0 || score !== 8'd0 || pos_x !== 10'd0) begin
      n_bad++;
      $display("FAIL dead_exit: over=%0b score=%0d pos_x=%0d want 0/0/0", game_over, score, pos_x);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_charge();
    test_saturation();
    test_interference();
    test_reset_mid_flight();
    test_random();
    test_inverted_window();
    test_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
